bank_wb_ctrl: RTL and testbench

- Write-back controller that owns the write side of the 32x32 register bank.
- Accepts register-write requests from the pipeline through a valid/ready handshake and buffers them in a small FIFO.
- Drains the FIFO one write per cycle onto the bank's Rw/Dir/DIn port.
- Forwards still-pending write data to the two read ports, so reads never return stale bank contents.

---
 rtl/bank_wb_ctrl.sv | 134 +++++++++++++
 tb/tb_bank_wb_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bank_wb_ctrl.sv
// rtl/bank_wb_ctrl.sv - write-back controller with pending-write FIFO and read forwarding
module bank_wb_ctrl #(
   parameter  int DEPTH = 4,
   parameter  int AW    = 5,
   parameter  int DW    = 32,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          drain_en,
   input  logic [AW-1:0] Rd1,
   input  logic [AW-1:0] Rd2,
   output logic          hit1,
   output logic          hit2,
   output logic [DW-1:0] fwd1,
   output logic [DW-1:0] fwd2,
   output logic          Rw,
   output logic [AW-1:0] Dir,
   output logic [DW-1:0] DIn,
   output logic [CW-1:0] pend_cnt
);

   // pending-write storage; contents are don't-care after reset
   logic [AW-1:0] mem_addr_q [DEPTH];
   logic [DW-1:0] mem_data_q [DEPTH];

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   // bank write port output stage
   logic          rw_q, rw_d;
   logic [AW-1:0] dir_q, dir_d;
   logic [DW-1:0] din_q, din_d;

   logic push;
   logic pop;

   // read-port lookup plumbing, indexed by port
   logic [AW-1:0] rd_sel [2];
   logic          hit_v  [2];
   logic [DW-1:0] fwd_v  [2];

   // ready depends only on registered occupancy, never on a same-cycle pop;
   // writes to register 0 are accepted but never enqueued
   assign wr_ready = (count_q < CW'(DEPTH));
   assign push     = wr_valid & wr_ready & (wr_addr != '0);
   assign pop      = drain_en & (count_q != '0);

   // next-state for pointers, occupancy and the bank write stage
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + CW'(push) - CW'(pop);
      rw_d    = pop;
      dir_d   = dir_q;
      din_d   = din_q;
      if (push) begin
         tail_d = tail_q + PW'(1);
      end
      if (pop) begin
         head_d = head_q + PW'(1);
         dir_d  = mem_addr_q[head_q];
         din_d  = mem_data_q[head_q];
      end
   end

   // control state; reset discards all pending writes and the output stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         rw_q    <= 1'b0;
         dir_q   <= '0;
         din_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         rw_q    <= rw_d;
         dir_q   <= dir_d;
         din_q   <= din_d;
      end
   end

   // FIFO entry write at the tail
   always_ff @(posedge clk) begin
      if (push) begin
         mem_addr_q[tail_q] <= wr_addr;
         mem_data_q[tail_q] <= wr_data;
      end
   end

   assign rd_sel[0] = Rd1;
   assign rd_sel[1] = Rd2;

   // forwarding search: scan oldest to youngest so the youngest match wins;
   // the output stage is older than every FIFO entry
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         hit_v[k] = 1'b0;
         fwd_v[k] = '0;
         if (rd_sel[k] != '0) begin
            if (rw_q && (dir_q == rd_sel[k])) begin
               hit_v[k] = 1'b1;
               fwd_v[k] = din_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
               if ((CW'(i) < count_q) &&
                   (mem_addr_q[head_q + PW'(i)] == rd_sel[k])) begin
                  hit_v[k] = 1'b1;
                  fwd_v[k] = mem_data_q[head_q + PW'(i)];
               end
            end
         end
      end
   end

   assign hit1     = hit_v[0];
   assign hit2     = hit_v[1];
   assign fwd1     = fwd_v[0];
   assign fwd2     = fwd_v[1];
   assign Rw       = rw_q;
   assign Dir      = dir_q;
   assign DIn      = din_q;
   assign pend_cnt = count_q;

endmodule

// File: tb/tb_bank_wb_ctrl.sv
// tb/tb_bank_wb_ctrl.sv - directed table-driven bench for bank_wb_ctrl
module tb_bank_wb_ctrl;

   logic        clk;
   logic        rst;
   logic        wr_valid;
   logic        wr_ready;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        drain_en;
   logic [4:0]  Rd1;
   logic [4:0]  Rd2;
   logic        hit1;
   logic        hit2;
   logic [31:0] fwd1;
   logic [31:0] fwd2;
   logic        Rw;
   logic [4:0]  Dir;
   logic [31:0] DIn;
   logic [2:0]  pend_cnt;

   int total;
   int bad;

   bank_wb_ctrl #(.DEPTH(4), .AW(5), .DW(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .drain_en (drain_en),
      .Rd1      (Rd1),
      .Rd2      (Rd2),
      .hit1     (hit1),
      .hit2     (hit2),
      .fwd1     (fwd1),
      .fwd2     (fwd2),
      .Rw       (Rw),
      .Dir      (Dir),
      .DIn      (DIn),
      .pend_cnt (pend_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wv;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        de;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic        rdy;
      logic [2:0]  pend;
      logic        rw;
      logic [4:0]  dir;
      logic [31:0] din;
      logic        h1;
      logic [31:0] f1;
      logic        h2;
      logic [31:0] f2;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", nm, idx, act, exp);
      end
   endtask

   task automatic add(input logic wv, input logic [4:0] wa, input logic [31:0] wd, input logic de,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic rdy, input logic [2:0] pend, input logic rw, input logic [4:0] dir,
                      input logic [31:0] din, input logic h1, input logic [31:0] f1,
                      input logic h2, input logic [31:0] f2);
      vec_t v;
      v.wv = wv; v.wa = wa; v.wd = wd; v.de = de; v.r1 = r1; v.r2 = r2;
      v.rdy = rdy; v.pend = pend; v.rw = rw; v.dir = dir; v.din = din;
      v.h1 = h1; v.f1 = f1; v.h2 = h2; v.f2 = f2;
      vecs.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] got_addr[$];
   logic [31:0] got_data[$];

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      drain_en = 1'b0; Rd1 = '0; Rd2 = '0;

      // each row: inputs applied, outputs expected before the consuming edge
      //  wv wa  wd            de r1 r2  rdy pnd rw dir din           h1 f1            h2 f2
      add(0, 0, 32'h0,        0, 0, 0,  1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
      add(1, 5, 32'hDEADBEEF, 1, 5, 0,  1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
      add(0, 0, 32'h0,        1, 5, 0,  1, 1, 0, 0, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0);
      add(0, 0, 32'h0,        1, 5, 0,  1, 0, 1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 32'h0);
      add(0, 0, 32'h0,        1, 5, 0,  1, 0, 0, 5, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0);
      add(1, 1, 32'h11,       0, 1, 0,  1, 0, 0, 5, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0);
      add(1, 2, 32'h22,       0, 1, 0,  1, 1, 0, 5, 32'hDEADBEEF, 1, 32'h11,       0, 32'h0);
      add(1, 3, 32'h33,       0, 1, 0,  1, 2, 0, 5, 32'hDEADBEEF, 1, 32'h11,       0, 32'h0);
      add(1, 4, 32'h44,       0, 1, 0,  1, 3, 0, 5, 32'hDEADBEEF, 1, 32'h11,       0, 32'h0);
      add(1, 9, 32'h99,       0, 4, 9,  0, 4, 0, 5, 32'hDEADBEEF, 1, 32'h44,       0, 32'h0);
      add(1, 9, 32'h99,       1, 4, 9,  0, 4, 0, 5, 32'hDEADBEEF, 1, 32'h44,       0, 32'h0);
      add(1, 9, 32'h99,       1, 4, 9,  1, 3, 1, 1, 32'h11,       1, 32'h44,       0, 32'h0);
      add(0, 0, 32'h0,        1, 4, 9,  1, 3, 1, 2, 32'h22,       1, 32'h44,       1, 32'h99);
      add(0, 0, 32'h0,        1, 4, 9,  1, 2, 1, 3, 32'h33,       1, 32'h44,       1, 32'h99);
      add(0, 0, 32'h0,        1, 4, 9,  1, 1, 1, 4, 32'h44,       1, 32'h44,       1, 32'h99);
      add(0, 0, 32'h0,        1, 4, 9,  1, 0, 1, 9, 32'h99,       0, 32'h0,        1, 32'h99);
      add(0, 0, 32'h0,        1, 4, 9,  1, 0, 0, 9, 32'h99,       0, 32'h0,        0, 32'h0);
      add(1, 0, 32'h1234,     1, 0, 0,  1, 0, 0, 9, 32'h99,       0, 32'h0,        0, 32'h0);
      add(0, 0, 32'h0,        1, 0, 0,  1, 0, 0, 9, 32'h99,       0, 32'h0,        0, 32'h0);
      add(0, 0, 32'h0,        1, 0, 0,  1, 0, 0, 9, 32'h99,       0, 32'h0,        0, 32'h0);
      add(1, 7, 32'hA,        0, 7, 8,  1, 0, 0, 9, 32'h99,       0, 32'h0,        0, 32'h0);
      add(1, 7, 32'hB,        0, 7, 8,  1, 1, 0, 9, 32'h99,       1, 32'hA,        0, 32'h0);
      add(0, 0, 32'h0,        0, 7, 8,  1, 2, 0, 9, 32'h99,       1, 32'hB,        0, 32'h0);
      add(0, 0, 32'h0,        1, 7, 8,  1, 2, 0, 9, 32'h99,       1, 32'hB,        0, 32'h0);
      add(0, 0, 32'h0,        0, 7, 8,  1, 1, 1, 7, 32'hA,        1, 32'hB,        0, 32'h0);
      add(0, 0, 32'h0,        1, 7, 8,  1, 1, 0, 7, 32'hA,        1, 32'hB,        0, 32'h0);
      add(0, 0, 32'h0,        0, 7, 8,  1, 0, 1, 7, 32'hB,        1, 32'hB,        0, 32'h0);
      add(0, 0, 32'h0,        0, 7, 8,  1, 0, 0, 7, 32'hB,        0, 32'h0,        0, 32'h0);

      // reset state while rst is held
      #2;
      chk("rst_rw",   -1, 32'(Rw),       32'h0);
      chk("rst_pend", -1, 32'(pend_cnt), 32'h0);
      chk("rst_dir",  -1, 32'(Dir),      32'h0);
      chk("rst_din",  -1, DIn,           32'h0);
      #10;
      rst = 1'b0;
      step();

      foreach (vecs[n]) begin
         wr_valid = vecs[n].wv; wr_addr = vecs[n].wa; wr_data = vecs[n].wd;
         drain_en = vecs[n].de; Rd1 = vecs[n].r1; Rd2 = vecs[n].r2;
         #1;
         chk("wr_ready", n, 32'(wr_ready), 32'(vecs[n].rdy));
         chk("pend_cnt", n, 32'(pend_cnt), 32'(vecs[n].pend));
         chk("Rw",       n, 32'(Rw),       32'(vecs[n].rw));
         chk("Dir",      n, 32'(Dir),      32'(vecs[n].dir));
         chk("DIn",      n, DIn,           vecs[n].din);
         chk("hit1",     n, 32'(hit1),     32'(vecs[n].h1));
         chk("fwd1",     n, fwd1,          vecs[n].f1);
         chk("hit2",     n, 32'(hit2),     32'(vecs[n].h2));
         chk("fwd2",     n, fwd2,          vecs[n].f2);
         step();
      end

      // six writes through the 4-deep FIFO, steady push+pop at occupancy 2
      Rd1 = '0; Rd2 = '0;
      for (int c = 0; c < 12; c++) begin
         wr_valid = (c < 6);
         wr_addr  = 5'(10 + c);
         wr_data  = 32'h100 + 32'(c);
         drain_en = (c >= 2);
         #1;
         if (c >= 3 && c <= 5) chk("wrap_pend", c, 32'(pend_cnt), 32'h2);
         if (Rw) begin
            got_addr.push_back(32'(Dir));
            got_data.push_back(DIn);
         end
         step();
      end
      chk("wrap_count", 0, 32'(got_addr.size()), 32'd6);
      for (int j = 0; j < 6; j++) begin
         if (j < got_addr.size()) begin
            chk("wrap_dir", j, got_addr[j], 32'(10 + j));
            chk("wrap_din", j, got_data[j], 32'h100 + 32'(j));
         end
      end
      chk("wrap_empty", 0, 32'(pend_cnt), 32'h0);

      // async reset mid-drain
      drain_en = 1'b0;
      for (int c = 0; c < 4; c++) begin
         wr_valid = 1'b1;
         wr_addr  = 5'(20 + c);
         wr_data  = 32'h200 + 32'(c);
         drain_en = (c == 3);
         #1;
         step();
      end
      wr_valid = 1'b0; drain_en = 1'b1; Rd1 = 5'd21; Rd2 = 5'd23;
      #1;
      chk("pre_rst_pend", 0, 32'(pend_cnt), 32'h3);
      chk("pre_rst_rw",   0, 32'(Rw),       32'h1);
      chk("pre_rst_hit1", 0, 32'(hit1),     32'h1);
      chk("pre_rst_hit2", 0, 32'(hit2),     32'h1);
      rst = 1'b1;
      #1;
      chk("mid_rst_rw",   0, 32'(Rw),       32'h0);
      chk("mid_rst_pend", 0, 32'(pend_cnt), 32'h0);
      chk("mid_rst_hit1", 0, 32'(hit1),     32'h0);
      chk("mid_rst_hit2", 0, 32'(hit2),     32'h0);
      chk("mid_rst_fwd1", 0, fwd1,          32'h0);
      chk("mid_rst_fwd2", 0, fwd2,          32'h0);
      rst = 1'b0;
      step();
      for (int c = 0; c < 6; c++) begin
         #1;
         chk("post_rst_rw",   c, 32'(Rw),       32'h0);
         chk("post_rst_pend", c, 32'(pend_cnt), 32'h0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
